// File: rtl/sig_mon_pkg.sv
// Shared types and helpers for the sig_monitor signature checker.
package sig_mon_pkg;

   // Checker phases: idle/preload, snooping, word-by-word compare, result hold.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Default bus geometry; modules derive their own lane count from DATA_W.
   localparam int DEF_DATA_W = 32;
   localparam int BYTES      = DEF_DATA_W / 8;

   // Byte offset inside the signature window -> word index (low bits dropped).
   function automatic int unsigned addr_to_idx(input logic [31:0] offset,
                                               input int unsigned lane_shift);
      return offset >> lane_shift;
   endfunction

endpackage

// File: rtl/sig_mon_shadow.sv
// Shadow copy of the signature window: byte-enable merge on write, plus a
// per-word written mask. Cleared by reset or by arming a new run.
module sig_mon_shadow
   import sig_mon_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int SIG_WORDS = 4,
   parameter int AW        = 2
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                i_clr,
   input  logic                i_we,
   input  logic [AW-1:0]       i_widx,
   input  logic [DATA_W-1:0]   i_wdata,
   input  logic [DATA_W/8-1:0] i_wbe,
   input  logic [AW-1:0]       i_ridx,
   output logic [DATA_W-1:0]   o_rdata,
   output logic                o_written
);

   localparam int NB = DATA_W / 8;

   logic [DATA_W-1:0]    r_mem [SIG_WORDS];
   logic [SIG_WORDS-1:0] r_written;

   // Clear on reset/arm, otherwise merge the enabled lanes of a window store.
   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         for (int i = 0; i < SIG_WORDS; i++) r_mem[i] <= '0;
         r_written <= '0;
      end else if (i_we) begin
         for (int b = 0; b < NB; b++) begin
            if (i_wbe[b]) r_mem[i_widx][b*8 +: 8] <= i_wdata[b*8 +: 8];
         end
         r_written[i_widx] <= 1'b1;
      end
   end

   assign o_rdata   = r_mem[i_ridx];
   assign o_written = r_written[i_ridx];

endmodule

// File: rtl/sig_monitor.sv
// End-of-test signature checker: shadows stores into the signature window,
// waits for a tohost store (or a timeout), then compares one word per cycle
// against the preloaded expected signature.
// Optional macro SIG_MON_UNWRITTEN_CHK_EN: a never-written signature word
// counts as a mismatch whatever its expected value.
module sig_monitor
   import sig_mon_pkg::*;
#(
   parameter int                ADDR_W      = 32,
   parameter int                DATA_W      = 32,
   parameter logic [ADDR_W-1:0] SIG_BASE    = 32'h0001_0000,
   parameter int                SIG_WORDS   = 4,
   parameter logic [ADDR_W-1:0] TOHOST_ADDR = 32'h0001_0100,
   parameter int                TIMEOUT_CYC = 1000
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         mon_we,
   input  logic [ADDR_W-1:0]            mon_addr,
   input  logic [DATA_W-1:0]            mon_wdata,
   input  logic [DATA_W/8-1:0]          mon_be,
   input  logic                         exp_we,
   input  logic [$clog2(SIG_WORDS):0]   exp_idx,
   input  logic [DATA_W-1:0]            exp_wdata,
   output logic                         busy,
   output logic                         done,
   output logic                         pass,
   output logic                         timeout,
   output logic [$clog2(SIG_WORDS):0]   err_count,
   output logic [$clog2(SIG_WORDS):0]   err_idx,
   output logic [31:0]                  cycle_count
);

   localparam int                NB       = DATA_W / 8;
   localparam int                IW       = $clog2(SIG_WORDS) + 1;
   localparam int                AW       = (SIG_WORDS > 1) ? $clog2(SIG_WORDS) : 1;
   localparam logic [IW-1:0]     NWORDS   = IW'(SIG_WORDS);
   localparam logic [IW-1:0]     LAST_IDX = IW'(SIG_WORDS - 1);
   localparam logic [ADDR_W:0]   WIN_LO   = {1'b0, SIG_BASE};
   localparam logic [ADDR_W:0]   WIN_HI   = WIN_LO + (ADDR_W+1)'(SIG_WORDS * NB);
   localparam logic [31:0]       TO_LAST  = 32'(TIMEOUT_CYC - 1);

   state_e              r_state;
   state_e              w_next;
   logic [31:0]         r_cycle;
   logic                r_timeout;
   logic [IW-1:0]       r_err_count;
   logic [IW-1:0]       r_err_idx;
   logic [IW-1:0]       r_chk_idx;
   logic [DATA_W-1:0]   r_exp [SIG_WORDS];

   logic                w_arm;
   logic                w_in_win;
   logic                w_tohost;
   logic                w_run_to;
   logic                w_sh_we;
   logic [AW-1:0]       w_sh_widx;
   logic [AW-1:0]       w_sh_ridx;
   logic [DATA_W-1:0]   w_rdata;
   logic                w_written;
   logic                w_mismatch;

   // start only re-arms from IDLE or DONE; it is ignored while busy.
   assign w_arm     = start && ((r_state == IDLE) || (r_state == DONE));
   assign w_in_win  = mon_we && ({1'b0, mon_addr} >= WIN_LO) && ({1'b0, mon_addr} < WIN_HI);
   assign w_tohost  = mon_we && (mon_addr == TOHOST_ADDR) && mon_wdata[0];
   assign w_run_to  = (r_cycle == TO_LAST);
   assign w_sh_we   = (r_state == RUN) && w_in_win;
   assign w_sh_widx = AW'(addr_to_idx(32'(mon_addr - SIG_BASE), $clog2(NB)));
   assign w_sh_ridx = r_chk_idx[AW-1:0];

   sig_mon_shadow #(
      .DATA_W    (DATA_W),
      .SIG_WORDS (SIG_WORDS),
      .AW        (AW)
   ) u_shadow (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (w_arm),
      .i_we      (w_sh_we),
      .i_widx    (w_sh_widx),
      .i_wdata   (mon_wdata),
      .i_wbe     (mon_be),
      .i_ridx    (w_sh_ridx),
      .o_rdata   (w_rdata),
      .o_written (w_written)
   );

   // Word compare for the current CHECK index.
   always_comb begin
      w_mismatch = 1'b0;
`ifdef SIG_MON_UNWRITTEN_CHK_EN
      w_mismatch = !w_written || (w_rdata != r_exp[w_sh_ridx]);
`else
      w_mismatch = ((w_written ? w_rdata : '0) != r_exp[w_sh_ridx]);
`endif
   end

   // Expected signature: writable only in IDLE, deliberately not reset.
   always_ff @(posedge clk) begin
      if (exp_we && (r_state == IDLE) && (exp_idx < NWORDS)) begin
         r_exp[exp_idx[AW-1:0]] <= exp_wdata;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic; tohost has priority over the timeout.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = RUN;
         RUN:     if (w_tohost || w_run_to) w_next = CHECK;
         CHECK:   if (r_chk_idx == LAST_IDX) w_next = DONE;
         DONE:    if (start) w_next = RUN;
         default: w_next = IDLE;
      endcase
   end

   // Run counter, timeout flag and compare results.
   always_ff @(posedge clk) begin
      if (rst || w_arm) begin
         r_cycle     <= '0;
         r_timeout   <= 1'b0;
         r_err_count <= '0;
         r_err_idx   <= '1;
         r_chk_idx   <= '0;
      end else begin
         case (r_state)
            RUN: begin
               if (r_cycle != '1) r_cycle <= r_cycle + 32'd1;
               if (!w_tohost && w_run_to) r_timeout <= 1'b1;
            end
            CHECK: begin
               r_chk_idx <= r_chk_idx + 1'b1;
               if (w_mismatch) begin
                  r_err_count <= r_err_count + 1'b1;
                  if (r_err_count == '0) r_err_idx <= r_chk_idx;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy        = (r_state == RUN) || (r_state == CHECK);
   assign done        = (r_state == DONE);
   assign pass        = done && (r_err_count == '0) && !r_timeout;
   assign timeout     = r_timeout;
   assign err_count   = r_err_count;
   assign err_idx     = r_err_idx;
   assign cycle_count = r_cycle;

endmodule

// File: tb/tb_sig_monitor.sv
// Bench for sig_monitor: directed runs from the test plan followed by
// randomized runs, all checked against a word/byte level reference model.
module tb_sig_monitor;

  localparam int          SW     = 4;
  localparam int          IW     = 3;
  localparam int          TO     = 50;
  localparam logic [31:0] BASE   = 32'h0001_0000;
  localparam logic [31:0] TOHOST = 32'h0001_0100;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst = 1'b0, start = 1'b0, mon_we = 1'b0, exp_we = 1'b0;
  logic [31:0] mon_addr = '0, mon_wdata = '0, exp_wdata = '0;
  logic [3:0]  mon_be = '0;
  logic [IW-1:0] exp_idx = '0;
  logic busy, done, pass, timeout;
  logic [IW-1:0] err_count, err_idx;
  logic [31:0] cycle_count;

  always #5 clk = ~clk;

  sig_monitor #(
    .ADDR_W(32), .DATA_W(32), .SIG_BASE(BASE), .SIG_WORDS(SW),
    .TOHOST_ADDR(TOHOST), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .mon_we(mon_we), .mon_addr(mon_addr), .mon_wdata(mon_wdata), .mon_be(mon_be),
    .exp_we(exp_we), .exp_idx(exp_idx), .exp_wdata(exp_wdata),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .err_idx(err_idx), .cycle_count(cycle_count)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
  endtask

  // ---------------- reference model ----------------
  // phase: 0 = idle, 1 = running, 2 = run finished (check/done)
  int          m_phase = 0;
  int          m_cyc   = 0;
  bit          m_to    = 0;
  logic [31:0] m_exp [SW];
  logic [31:0] m_sh  [SW];
  bit          m_wr  [SW];

  task automatic model_clear();
    for (int i = 0; i < SW; i++) begin m_sh[i] = '0; m_wr[i] = 0; end
    m_cyc = 0;
    m_to  = 0;
  endtask

  // One cycle of a running test as the rules describe it.
  task automatic model_tick(input logic we, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] be);
    int w;
    if (we && addr >= BASE && addr < BASE + 32'(SW * 4)) begin
      w = int'((addr - BASE) / 4);
      for (int b = 0; b < 4; b++)
        if (be[b]) m_sh[w][b*8 +: 8] = data[b*8 +: 8];
      m_wr[w] = 1;
    end
    if (we && addr == TOHOST && data[0]) m_phase = 2;
    else if (m_cyc == TO - 1) begin m_to = 1; m_phase = 2; end
    m_cyc++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_cycle(input logic st, input logic we, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] be,
                             input logic ew, input logic [IW-1:0] eidx, input logic [31:0] ewd);
    int ph0;
    ph0 = m_phase;
    start = st; mon_we = we; mon_addr = addr; mon_wdata = data; mon_be = be;
    exp_we = ew; exp_idx = eidx; exp_wdata = ewd;
    tick();
    start = 0; mon_we = 0; exp_we = 0;
    if (ew && ph0 == 0 && eidx < IW'(SW)) m_exp[eidx[1:0]] = ewd;
    if (st && ph0 != 1) begin model_clear(); m_phase = 1; end
    else if (ph0 == 1) model_tick(we, addr, data, be);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    drive_cycle(0, 1, addr, data, be, 0, '0, '0);
  endtask

  task automatic store_word(input int i, input logic [31:0] data);
    store(BASE + 32'(4 * i), data, 4'hF);
  endtask

  task automatic idle();
    drive_cycle(0, 0, '0, '0, '0, 0, '0, '0);
  endtask

  task automatic preload(input logic [IW-1:0] i, input logic [31:0] v);
    drive_cycle(0, 0, '0, '0, '0, 1, i, v);
  endtask

  task automatic start_pulse();
    drive_cycle(1, 0, '0, '0, '0, 0, '0, '0);
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
    m_phase = 0;
    model_clear();
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_busy"},    32'(busy),        32'd0);
    check_val({tag, "_done"},    32'(done),        32'd0);
    check_val({tag, "_pass"},    32'(pass),        32'd0);
    check_val({tag, "_timeout"}, 32'(timeout),     32'd0);
    check_val({tag, "_errcnt"},  32'(err_count),   32'd0);
    check_val({tag, "_erridx"},  32'(err_idx),     32'd7);
    check_val({tag, "_cycles"},  cycle_count,      32'd0);
  endtask

  // Predict the verdict, wait (bounded) for done, then compare everything.
  task automatic finish_run(input string tag);
    int ec, ei, n;
    logic [31:0] v;
    bit mm;
    ec = 0; ei = 7;
    for (int i = 0; i < SW; i++) begin
      v  = m_wr[i] ? m_sh[i] : 32'd0;
      mm = (v != m_exp[i]);
`ifdef SIG_MON_UNWRITTEN_CHK_EN
      if (!m_wr[i]) mm = 1;
`endif
      if (mm) begin
        if (ec == 0) ei = i;
        ec++;
      end
    end
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'(ec));
    exp_q.push_back(32'(ei));
    exp_q.push_back(32'((ec == 0) && !m_to));
    exp_q.push_back(32'(m_to));
    exp_q.push_back(32'(m_cyc));
    n = 0;
    while (!done && n < 20) begin idle(); n++; end
    check_val({tag, "_chk_len"}, 32'(n), 32'(SW));
    check_val({tag, "_done"},    32'(done),      exp_q.pop_front());
    check_val({tag, "_busy"},    32'(busy),      exp_q.pop_front());
    check_val({tag, "_errcnt"},  32'(err_count), exp_q.pop_front());
    check_val({tag, "_erridx"},  32'(err_idx),   exp_q.pop_front());
    check_val({tag, "_pass"},    32'(pass),      exp_q.pop_front());
    check_val({tag, "_timeout"}, 32'(timeout),   exp_q.pop_front());
    check_val({tag, "_cycles"},  cycle_count,    exp_q.pop_front());
  endtask

  function automatic logic [31:0] pick_val();
    return ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int i, nops;
    logic [31:0] orig [SW];
    orig[0] = 32'd10; orig[1] = 32'd20; orig[2] = 32'hFFFF_FFFB; orig[3] = 32'd15;
    for (int k = 0; k < SW; k++) m_exp[k] = '0;

    do_reset();
    check_idle_outputs("reset");

    // Matching run; out-of-range preload index is ignored.
    for (int k = 0; k < SW; k++) preload(IW'(k), orig[k]);
    preload(3'd5, 32'hDEAD_BEEF);
    start_pulse();
    check_val("run_busy", 32'(busy), 32'd1);
    check_val("run_done", 32'(done), 32'd0);
    for (int k = 0; k < SW; k++) store_word(k, orig[k]);
    store(TOHOST, 32'd1, 4'hF);
    finish_run("match");

    // Re-arm from DONE; word 2 wrong.
    start_pulse();
    store_word(0, orig[0]); store_word(1, orig[1]);
    store_word(2, 32'h0000_0014); store_word(3, orig[3]);
    store(TOHOST, 32'd1, 4'hF);
    finish_run("mismatch");

    // Byte-lane merge; word 1 written with low address bits set.
    do_reset();
    preload(3'd0, 32'h1122_AA44);
    start_pulse();
    store(BASE, 32'h1122_3344, 4'b1111);
    store(BASE, 32'h0000_AA00, 4'b0010);
    store(BASE + 32'd6, orig[1], 4'hF);
    store_word(2, orig[2]); store_word(3, orig[3]);
    store(TOHOST, 32'd1, 4'hF);
    finish_run("merge");

    // Timeout with tohost never written.
    start_pulse();
    for (int k = 0; k < SW; k++) store_word(k, orig[k]);
    while (m_phase == 1) idle();
    finish_run("timeout");

    // tohost in the very last RUN cycle wins over timeout.
    start_pulse();
    while (m_phase == 1 && m_cyc < TO - 1) idle();
    store(TOHOST, 32'd1, 4'hF);
    finish_run("late_tohost");

    // Reset mid-run: shadow cleared, expected array retained.
    do_reset();
    for (int k = 0; k < SW; k++) preload(IW'(k), orig[k]);
    start_pulse();
    store_word(2, 32'h0BAD_0BAD); store_word(3, 32'h0BAD_0BAD);
    do_reset();
    check_idle_outputs("midrst");
    rst = 1; start = 1; tick(); rst = 0; start = 0;
    check_val("rst_start_busy", 32'(busy), 32'd0);
    start_pulse();
    for (int k = 0; k < SW; k++) store_word(k, orig[k]);
    store(TOHOST, 32'd1, 4'hF);
    finish_run("after_rst");

    // Word 2 never written, expected zero.
    do_reset();
    preload(3'd2, 32'd0);
    start_pulse();
    store_word(0, orig[0]); store_word(1, orig[1]); store_word(3, orig[3]);
    store(TOHOST, 32'd1, 4'hF);
    finish_run("unwritten");

    // Randomized runs.
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_reset();
        for (int k = 0; k < 3; k++) preload(IW'($urandom_range(0, 7)), pick_val());
      end
      start_pulse();
      nops = $urandom_range(0, 12);
      for (int k = 0; k < nops && m_phase == 1; k++) begin
        case ($urandom_range(0, 7))
          0, 1, 2: begin
            i = $urandom_range(0, SW - 1);
            store(BASE + 32'(4 * i + $urandom_range(0, 3)),
                  ($urandom_range(0, 1) == 1) ? m_exp[i] : $urandom,
                  ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15)));
          end
          3: store(($urandom_range(0, 1) == 1) ? BASE - 32'd4 : BASE + 32'(16 + 4 * $urandom_range(0, 50)),
                   $urandom, 4'hF);
          4: store(TOHOST, $urandom & 32'hFFFF_FFFE, 4'hF);
          5: start_pulse();
          6: preload(IW'($urandom_range(0, 7)), $urandom);
          default: begin
            if ($urandom_range(0, 3) == 0) begin do_reset(); start_pulse(); end
            else idle();
          end
        endcase
      end
      if ($urandom_range(0, 9) == 0) begin
        while (m_phase == 1) idle();
      end else if (m_phase == 1) begin
        store(TOHOST, $urandom | 32'd1, 4'hF);
      end
      finish_run("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sig_monitor.md
Name: sig_monitor

Overview:
- Parametrised, synthesizable end-of-test signature checker for the RV32I cores (single-cycle now, pipelined later).
- Snoops the core's data-memory store bus and shadows a configurable signature window.
- Detects program completion via a store to a tohost address and compares the shadow against an expected signature preloaded by the bench.
- Reports pass/fail, mismatch count, first failing index and cycle count; replaces hard-coded per-test hierarchical peeks.

Parameters:
- ADDR_W, 32, store-bus address width.
- DATA_W, 32, store-bus data width; must be a multiple of 8.
- SIG_BASE, 32'h0001_0000, byte address of signature word 0; DATA_W/8 aligned.
- SIG_WORDS, 4, number of signature words; 1..256.
- TOHOST_ADDR, 32'h0001_0100, byte address whose store ends the test.
- TIMEOUT_CYC, 1000, RUN cycles before timeout; must be ≥1.

Ports:
- clk, in, 1, clock; all state updates on its rising edge.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, one-cycle pulse; IDLE->RUN.
- mon_we, in, 1, core store strobe; qualifies one store per cycle.
- mon_addr, in, ADDR_W, store byte address.
- mon_wdata, in, DATA_W, store data, lane-aligned.
- mon_be, in, DATA_W/8, byte enables.
- exp_we, in, 1, expected-signature write strobe.
- exp_idx, in, $clog2(SIG_WORDS)+1, expected word index.
- exp_wdata, in, DATA_W, expected word value.
- busy, out, 1, high in RUN or CHECK.
- done, out, 1, high in DONE; held until rst or start.
- pass, out, 1, done and no mismatch and no timeout.
- timeout, out, 1, run ended by TIMEOUT_CYC.
- err_count, out, $clog2(SIG_WORDS)+1, number of mismatching words.
- err_idx, out, $clog2(SIG_WORDS)+1, first mismatching index; all-ones if none.
- cycle_count, out, 32, RUN cycles elapsed; saturates at 2^32-1.

Behaviour:
- Reset: state IDLE. busy, done, pass, timeout=0; err_count=0; err_idx=all-ones; cycle_count=0; shadow words and written mask cleared. Expected array is NOT cleared, so preloads survive a mid-test rst.
- IDLE:
  - exp_we writes exp[exp_idx] (ignored in other states).
  - exp_idx ≥ SIG_WORDS is ignored.
  - start clears shadow, mask, counters and flags, then -> RUN.
- RUN:
  - cycle_count increments every cycle.
  - A store with mon_we and SIG_BASE ≤ mon_addr < SIG_BASE + SIG_WORDS*DATA_W/8 merges enabled bytes into shadow[(addr-SIG_BASE)>>log2(DATA_W/8)] and sets that word's written bit.
  - Low address bits are ignored.
  - Stores outside the window are ignored.
  - Store to TOHOST_ADDR with mon_wdata[0]=1 -> CHECK on the next cycle.
  - If cycle_count reaches TIMEOUT_CYC-1 without tohost: timeout=1, -> CHECK.
  - tohost and timeout in the same cycle: tohost wins, timeout=0.
  - start during RUN is ignored.
- CHECK:
  - Compares one word per cycle, index 0..SIG_WORDS-1, so it lasts exactly SIG_WORDS cycles.
  - On a mismatch, err_count increments; err_idx is latched on the first mismatch only.
  - After the last word -> DONE.
- DONE:
  - done=1; pass=(err_count==0)&&!timeout.
  - start re-arms directly to RUN, with the same clearing as from IDLE.
- rst at any cycle overrides everything, including a simultaneous start.

Optional Feature:
- Macro: SIG_MON_UNWRITTEN_CHK_EN.
- Defined: a signature word whose written bit is 0 at CHECK counts as a mismatch regardless of value.
- Undefined: unwritten words compare as 0 against expected.

Decomposition:
- Package sig_mon_pkg holds:
  - state enum typedef {IDLE, RUN, CHECK, DONE};
  - function addr_to_idx;
  - localparam BYTES = DATA_W/8.
- One sub-module, sig_mon_shadow: the shadow word array with byte-enable merge and written mask; write port from RUN, read port indexed by the CHECK counter.

Test Plan:
- Matching run: preload {10, 20, 0xFFFF_FFFB, 15}, start, store those four words at 0x10000..0x1000C, then store 1 to 0x10100 -> after 4 CHECK cycles: done=1, pass=1, err_count=0, err_idx=all-ones.
- Mismatch: same preload, store 0x0000_0014 to word 2, then tohost -> pass=0, err_count=1, err_idx=2.
- Byte merge: store 0x11223344 with be=4'b1111, then 0x0000AA00 with be=4'b0010 to word 0 -> shadow[0]=0x1122AA44; matches when expected=0x1122AA44.
- Timeout: TIMEOUT_CYC=50, never write tohost -> timeout=1, pass=0, cycle_count=50; tohost stored in cycle 49 instead -> timeout=0.
- rst mid-RUN after two stores, then start plus matching stores -> shadow starts cleared, preload retained, pass=1.
- Unwritten word: only words 0,1,3 written and exp[2]=0 -> pass=1 without SIG_MON_UNWRITTEN_CHK_EN; pass=0, err_idx=2 with it.
